// File: rtl/apb4_regfile.sv
// ---------------------------------------------------------------------------
// apb4_regfile
//   APB4 completer holding NUM_REGS memory-mapped registers. Supports a fixed
//   number of access-phase wait states, PSTRB byte-lane writes, read-only
//   registers whose read value comes from hw_rdata, and PSLVERR on unaligned,
//   out-of-range, or read-only-write accesses.
//
// Ports
//   PCLK      in   clock, every flop on the rising edge
//   PRESET    in   synchronous active-high reset
//   PADDR     in   byte address
//   PSEL      in   completer select
//   PENABLE   in   access phase indicator
//   PWRITE    in   1 = write, 0 = read
//   PWDATA    in   write data
//   PSTRB     in   write byte strobes
//   PRDATA    out  read data (zero unless a clean read is completing)
//   PREADY    out  high for exactly the completion cycle
//   PSLVERR   out  error flag, only meaningful while PREADY is high
//   hw_rdata  in   status words for read-only registers, reg i at [i*DW +: DW]
//   reg_q     out  current register contents; read-only slots read 0
//   wr_pulse  out  one-hot pulse, bit i high in the cycle after reg i commits
// ---------------------------------------------------------------------------
module apb4_regfile #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);
  // One extra bit so NUM_REGS == 2**(ADDR_WIDTH-OFS) still compares correctly.
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFS) - 1);
  localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;

  logic [AW1-1:0]        idx;
  logic [NUM_REGS-1:0]   hit_vec;
  logic                  sel_ro;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  misalign;
  logic                  err;
  logic                  completing;
  logic                  commit;

  // Replace the strobed byte lanes of old_val with the matching lanes of new_val.
  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [NB-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] res;
    for (int b = 0; b < NB; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  assign idx = {1'b0, addr_q} >> OFS;

  // Decode the latched address: register hit, read-only flag, read value, error.
  always_comb begin
    hit_vec  = '0;
    sel_ro   = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit_vec[i] = (idx == AW1'(i));
      sel_ro     = sel_ro | (hit_vec[i] & RO_MASK[i]);
      sel_data   = sel_data | ({DATA_WIDTH{hit_vec[i]}} &
                   (RO_MASK[i] ? hw_rdata[i*DATA_WIDTH +: DATA_WIDTH]
                               : reg_q[i*DATA_WIDTH +: DATA_WIDTH]));
    end
    misalign   = |(addr_q & ALIGN_MASK);
    // No hit bit set means the index is beyond the register bank.
    err        = misalign | ~(|hit_vec) | (write_q & sel_ro);
    completing = (state == ST_ACCESS) & (cnt == 4'd0);
    commit     = completing & write_q & ~err;
  end

  // Bus response: PREADY follows state/counter, data and error only while completing.
  always_comb begin
    PREADY  = completing;
    PSLVERR = completing & err;
    if (completing & ~write_q & ~err) begin
      PRDATA = sel_data;
    end else begin
      PRDATA = '0;
    end
  end

  // Transfer FSM: latch request on setup, count wait states, drop on abort.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            state   <= ST_ACCESS;
            cnt     <= WAIT_INIT;
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            state <= ST_IDLE;
          end else if (!PSEL) begin
            // Requester withdrew before completion: nothing is committed.
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Register bank and write pulse; read-only slots are held at zero.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i*DATA_WIDTH +: DATA_WIDTH] <= RO_MASK[i] ? '0 : RESET_VAL;
      end
      wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && !RO_MASK[i] && hit_vec[i]) begin
          reg_q[i*DATA_WIDTH +: DATA_WIDTH] <=
            byte_merge(reg_q[i*DATA_WIDTH +: DATA_WIDTH], wdata_q, strb_q);
        end
      end
      // Pulse fires on every clean write, including an all-zero strobe.
      wr_pulse <= commit ? hit_vec : '0;
    end
  end

endmodule

// File: tb/tb_apb4_regfile.sv
// ---------------------------------------------------------------------------
// tb_apb4_regfile
//   Drives APB transfers into apb4_regfile (3 wait states, register 3
//   read-only, non-zero reset value) and checks every output on every cycle
//   against a transfer-level model: a register array, the protocol latency
//   rule, and the address/error decode written as plain arithmetic.
// ---------------------------------------------------------------------------
module tb_apb4_regfile;

  localparam int          NR = 8;
  localparam int          W  = 3;
  localparam logic [7:0]  RO = 8'b0000_1000;
  localparam logic [31:0] RV = 32'hC0DE_0000;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic [11:0]  PADDR;
  logic         PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [31:0]  PRDATA;
  logic         PREADY;
  logic         PSLVERR;
  logic [255:0] hw_rdata;
  logic [255:0] reg_q;
  logic [7:0]   wr_pulse;

  apb4_regfile #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32),
    .NUM_REGS   (NR),
    .WAIT_STATES(W),
    .RO_MASK    (RO),
    .RESET_VAL  (RV)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .hw_rdata(hw_rdata),
    .reg_q   (reg_q),
    .wr_pulse(wr_pulse)
  );

  always #5 PCLK = ~PCLK;

  // Model state
  logic [31:0] mem [NR];
  logic [7:0]  exp_pulse = 8'h00;
  logic        exp_pready = 1'b0;
  logic        exp_pslverr = 1'b0;
  logic [31:0] exp_prdata = 32'h0;
  bit          pend = 1'b0;
  int          pend_idx;
  logic [31:0] pend_data;
  logic [3:0]  pend_strb;

  int total = 0;
  int passed = 0;
  bit check_en = 1'b0;

  // Values captured from the DUT for the hand-computed checks
  logic [31:0] cap_rdata;
  logic        cap_err;
  int          cap_lat;
  logic [7:0]  cap_pulse;
  int          lat = 0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, exp);
  endtask

  function automatic logic [255:0] exp_regq();
    logic [255:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = RO[i] ? 32'h0 : mem[i];
    return v;
  endfunction

  function automatic bit model_err(input logic [11:0] a, input logic w);
    int idx;
    idx = int'(a >> 2);
    if (a[1:0] != 2'b00) return 1'b1;
    if (idx >= NR) return 1'b1;
    return w && RO[idx];
  endfunction

  // Per-cycle compare, plus captures for the literal checks
  always @(negedge PCLK) begin
    if (check_en) begin
      chk("PREADY",   {255'h0, PREADY},  {255'h0, exp_pready});
      chk("PSLVERR",  {255'h0, PSLVERR}, {255'h0, exp_pslverr});
      chk("PRDATA",   {224'h0, PRDATA},  {224'h0, exp_prdata});
      chk("wr_pulse", {248'h0, wr_pulse}, {248'h0, exp_pulse});
      chk("reg_q",    reg_q, exp_regq());
    end
    if (PSEL === 1'b1 && PENABLE === 1'b0) lat = 0;
    else if (PSEL === 1'b1) lat++;
    if (PREADY === 1'b1) begin
      cap_rdata = PRDATA;
      cap_err   = PSLVERR;
      cap_lat   = lat;
    end
    if (wr_pulse !== 8'h00) cap_pulse = wr_pulse;
  end

  // One clock edge: apply reset or pending commit to the model
  task automatic step();
    @(posedge PCLK);
    if (PRESET) begin
      for (int i = 0; i < NR; i++) mem[i] = RV;
      exp_pulse = 8'h00;
    end else if (pend) begin
      for (int b = 0; b < 4; b++)
        if (pend_strb[b]) mem[pend_idx][8*b +: 8] = pend_data[8*b +: 8];
      exp_pulse = 8'h01 << pend_idx;
    end else begin
      exp_pulse = 8'h00;
    end
    pend = 1'b0;
    #1;
  endtask

  task automatic bus_idle();
    PSEL = 1'b0; PENABLE = 1'b0;
    exp_pready = 1'b0; exp_pslverr = 1'b0; exp_prdata = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Full APB transfer; abort_at/reset_at name an access cycle (1..W), -1 = none
  task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input int abort_at, input int reset_at);
    int idx;
    bit e;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s;
    exp_pready = 1'b0; exp_pslverr = 1'b0; exp_prdata = 32'h0;
    step();
    PENABLE = 1'b1;
    for (int k = 1; k <= W + 1; k++) begin
      if (k == W + 1) begin
        e = model_err(a, w);
        idx = int'(a >> 2);
        exp_pready  = 1'b1;
        exp_pslverr = e;
        if (!w && !e) exp_prdata = RO[idx] ? hw_rdata[idx*32 +: 32] : mem[idx];
        else exp_prdata = 32'h0;
        if (w && !e) begin
          pend = 1'b1; pend_idx = idx; pend_data = d; pend_strb = s;
        end
      end else begin
        exp_pready = 1'b0; exp_pslverr = 1'b0; exp_prdata = 32'h0;
        if (k == abort_at) begin
          PSEL = 1'b0; PENABLE = 1'b0;
          step();
          bus_idle();
          return;
        end
        if (k == reset_at) PRESET = 1'b1;
      end
      step();
      if (k == reset_at) begin
        PRESET = 1'b0;
        bus_idle();
        return;
      end
    end
    bus_idle();
  endtask

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    chk(nm, {224'h0, got}, {224'h0, exp});
  endtask

  initial begin
    logic [11:0] a;
    int r;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 12'h0; PWDATA = 32'h0; PSTRB = 4'h0;
    for (int i = 0; i < NR; i++) begin
      hw_rdata[i*32 +: 32] = $urandom;
      mem[i] = 32'h0;
    end
    cap_pulse = 8'h00;
    step();
    check_en = 1'b1;
    step();
    PRESET = 1'b0;
    step();

    // Read after reset: reset value, PREADY only in the 4th access cycle
    xfer(12'h000, 1'b0, 32'h0, 4'h0, -1, -1);
    lit("rst_read_data", cap_rdata, 32'hC0DE_0000);
    lit("rst_read_err", {31'h0, cap_err}, 32'h0);
    lit("latency", cap_lat, 32'd4);

    // Full write and read back, with pulse on bit 1
    cap_pulse = 8'h00;
    xfer(12'h004, 1'b1, 32'hDEAD_BEEF, 4'hF, -1, -1);
    step();
    lit("wr1_pulse", {24'h0, cap_pulse}, 32'h2);
    xfer(12'h004, 1'b0, 32'h0, 4'h0, -1, -1);
    lit("rd1_data", cap_rdata, 32'hDEAD_BEEF);

    // Byte-lane write
    xfer(12'h008, 1'b1, 32'h1122_3344, 4'hF, -1, -1);
    xfer(12'h008, 1'b1, 32'hAABB_CCDD, 4'b0101, -1, -1);
    xfer(12'h008, 1'b0, 32'h0, 4'h0, -1, -1);
    lit("strb_data", cap_rdata, 32'h11BB_33DD);
    lit("strb_model", mem[2], 32'h11BB_33DD);

    // Read-only register
    hw_rdata[3*32 +: 32] = 32'h0000_5A5A;
    cap_pulse = 8'h00;
    xfer(12'h00C, 1'b1, 32'hFFFF_FFFF, 4'hF, -1, -1);
    lit("ro_wr_err", {31'h0, cap_err}, 32'h1);
    step();
    lit("ro_wr_pulse", {24'h0, cap_pulse}, 32'h0);
    xfer(12'h00C, 1'b0, 32'h0, 4'h0, -1, -1);
    lit("ro_rd_data", cap_rdata, 32'h0000_5A5A);
    lit("ro_rd_err", {31'h0, cap_err}, 32'h0);

    // Out-of-range and unaligned accesses
    xfer(12'h020, 1'b0, 32'h0, 4'h0, -1, -1);
    lit("oor_err", {31'h0, cap_err}, 32'h1);
    lit("oor_data", cap_rdata, 32'h0);
    xfer(12'h002, 1'b0, 32'h0, 4'h0, -1, -1);
    lit("unal_err", {31'h0, cap_err}, 32'h1);
    xfer(12'h020, 1'b1, 32'h1234_5678, 4'hF, -1, -1);
    xfer(12'h006, 1'b1, 32'h1234_5678, 4'hF, -1, -1);

    // Zero strobe: data held, pulse still fires
    cap_pulse = 8'h00;
    xfer(12'h010, 1'b1, 32'h9999_9999, 4'h0, -1, -1);
    step();
    lit("strb0_pulse", {24'h0, cap_pulse}, 32'h10);

    // Abort mid-wait then read: no write happened
    xfer(12'h004, 1'b1, 32'h0, 4'hF, 2, -1);
    xfer(12'h004, 1'b0, 32'h0, 4'h0, -1, -1);
    lit("abort_data", cap_rdata, 32'hDEAD_BEEF);

    // Reset during the wait of a write, then a normal transfer
    xfer(12'h008, 1'b1, 32'h1234_5678, 4'hF, -1, 2);
    xfer(12'h008, 1'b0, 32'h0, 4'h0, -1, -1);
    lit("rst_mid_data", cap_rdata, 32'hC0DE_0000);

    // Randomized traffic, mostly back-to-back
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0) a = 12'($urandom);
      else if (r == 1) a = 12'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
      else a = 12'($urandom_range(0, 9) * 4);
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < NR; i++) hw_rdata[i*32 +: 32] = $urandom;
      xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
           ($urandom_range(0, 9) == 0) ? $urandom_range(1, W) : -1, -1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
